apb_rr_arbiter: RTL

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_ic_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/apb_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/apb_ic_pkg.sv
// Shared defaults and state type for the APB round-robin arbiter.
package apb_ic_pkg;

  localparam int unsigned DefNumSrc = 4;
  localparam int unsigned DefDataW  = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_SRC-1:0] grant_onehot_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_o          = 1'b0;
    idx            = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx = IDX_W'((32'(last_grant_i) + i) % NUM_SRC);
      if (!any_o && req_i[idx]) begin
        any_o               = 1'b1;
        grant_idx_o         = idx;
        grant_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter draining per-source request FIFOs onto a single APB master port.
module apb_rr_arbiter
  import apb_ic_pkg::*;
#(
  parameter int unsigned NUM_SRC = DefNumSrc,
  parameter int unsigned DATA_W  = DefDataW,
  localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             empty_i,
  input  logic [NUM_SRC-1:0]             write_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] pop_addr_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] pop_wdata_i,
  output logic [NUM_SRC-1:0]             pop_o,
  output logic                           psel_o,
  output logic                           penable_o,
  output logic                           pwrite_o,
  output logic [DATA_W-1:0]              paddr_o,
  output logic [DATA_W-1:0]              pwdata_o,
  input  logic                           pready_i,
  input  logic                           pslverr_i,
  input  logic [DATA_W-1:0]              prdata_i,
  output logic                           rsp_valid_o,
  output logic [IDX_W-1:0]               rsp_id_o,
  output logic [DATA_W-1:0]              rsp_rdata_o,
  output logic                           rsp_err_o
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, id_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              write_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [IDX_W-1:0]  rsp_id_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [NUM_SRC-1:0] grant_onehot;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               pop_en;
  logic               complete;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i          (~empty_i),
    .last_grant_i   (last_grant_q),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx),
    .any_o          (grant_any)
  );

  always_comb begin
    state_d   = state_q;
    pop_en    = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No pop while reset is held: the entry would be discarded at the edge.
        if (reset && grant_any) begin
          pop_en  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign complete = (state_q == ACCESS) && pready_i;
  assign pop_o    = pop_en ? grant_onehot : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      id_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop_en) begin
        last_grant_q <= grant_idx;
        id_q         <= grant_idx;
        addr_q       <= pop_addr_i[grant_idx];
        write_q      <= write_i[grant_idx];
        wdata_q      <= write_i[grant_idx] ? pop_wdata_i[grant_idx] : '0;
      end
      rsp_valid_q <= complete;
      rsp_id_q    <= complete ? id_q : '0;
      rsp_rdata_q <= (complete && !write_q) ? prdata_i : '0;
      rsp_err_q   <= complete && pslverr_i;
    end
  end

  assign pwrite_o    = write_q;
  assign paddr_o     = addr_q;
  assign pwdata_o    = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
